// File: rtl/conv_transpose2d.sv
// rtl/conv_transpose2d.sv - gather-style transposed 2D convolution engine over synchronous memories
module conv_transpose2d #(
    parameter int BATCH_SIZE   = 1,
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 2,
    parameter int IN_HEIGHT    = 2,
    parameter int IN_WIDTH     = 2,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int PADDING      = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  done,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] input_addr,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  input_en,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    input  logic [DATA_WIDTH-1:0] weight_data,
    output logic                  weight_en,
    output logic [ADDR_WIDTH-1:0] bias_addr,
    input  logic [DATA_WIDTH-1:0] bias_data,
    output logic                  bias_en,
    output logic [ADDR_WIDTH-1:0] output_addr,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_we,
    output logic                  output_en
);
    localparam int OUT_H = (IN_HEIGHT - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE;
    localparam int OUT_W = (IN_WIDTH - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_BWAIT, S_BIAS, S_TAP, S_TWAIT, S_MAC, S_STORE, S_NEXT, S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [31:0] r_b, r_oc, r_oh, r_ow, r_ic, r_kr, r_kc;
    logic [31:0] w_b_nxt, w_oc_nxt, w_oh_nxt, w_ow_nxt, w_ic_nxt, w_kr_nxt, w_kc_nxt;
    logic [31:0] w_ic_adv, w_kr_adv, w_kc_adv;
    logic [31:0] w_ih, w_iw;
    logic signed [2*DW-1:0] r_acc, w_acc_nxt, w_prod, w_in_ext, w_wt_ext, w_bias_ext;
    logic w_tap_last, w_pix_last, w_cur_ok, w_nxt_ok, w_rd;
    logic [AW-1:0] w_in_addr, w_wt_addr, w_out_addr;

    logic [AW-1:0] r_input_addr, r_weight_addr, r_bias_addr, r_output_addr;
    logic [DW-1:0] r_output_data;
    logic r_input_en, r_weight_en, r_bias_en, r_output_en, r_output_we, r_done;

    // A tap contributes only when the crop-adjusted offset lands exactly on a stride grid point inside the input.
    function automatic logic tap_ok(input logic [31:0] oh, input logic [31:0] ow,
                                    input logic [31:0] kr, input logic [31:0] kc);
        int t;
        int u;
        t = $signed(oh) + PADDING - $signed(kr);
        u = $signed(ow) + PADDING - $signed(kc);
        return (t >= 0) && (u >= 0) && (t % STRIDE == 0) && (u % STRIDE == 0) &&
               (t / STRIDE < IN_HEIGHT) && (u / STRIDE < IN_WIDTH);
    endfunction

    assign w_in_ext   = {{DW{input_data[DW-1]}}, input_data};
    assign w_wt_ext   = {{DW{weight_data[DW-1]}}, weight_data};
    assign w_bias_ext = {{DW{bias_data[DW-1]}}, bias_data};
    assign w_prod     = w_in_ext * w_wt_ext;

    assign w_tap_last = (r_ic == IN_CHANNELS - 1) && (r_kr == KERNEL_SIZE - 1) && (r_kc == KERNEL_SIZE - 1);
    assign w_pix_last = (r_b == BATCH_SIZE - 1) && (r_oc == OUT_CHANNELS - 1) &&
                        (r_oh == OUT_H - 1) && (r_ow == OUT_W - 1);
    assign w_cur_ok   = tap_ok(r_oh, r_ow, r_kr, r_kc);
    assign w_nxt_ok   = tap_ok(w_oh_nxt, w_ow_nxt, w_kr_nxt, w_kc_nxt);

    assign w_ih       = (w_oh_nxt + PADDING - w_kr_nxt) / STRIDE;
    assign w_iw       = (w_ow_nxt + PADDING - w_kc_nxt) / STRIDE;
    assign w_in_addr  = AW'(((w_b_nxt * IN_CHANNELS + w_ic_nxt) * IN_HEIGHT + w_ih) * IN_WIDTH + w_iw);
    assign w_wt_addr  = AW'(((w_ic_nxt * OUT_CHANNELS + w_oc_nxt) * KERNEL_SIZE + w_kr_nxt) * KERNEL_SIZE + w_kc_nxt);
    assign w_out_addr = AW'(((r_b * OUT_CHANNELS + r_oc) * OUT_H + r_oh) * OUT_W + r_ow);

    always_comb begin
        w_kc_adv = r_kc + 1;
        w_kr_adv = r_kr;
        w_ic_adv = r_ic;
        if (r_kc == KERNEL_SIZE - 1) begin
            w_kc_adv = '0;
            w_kr_adv = r_kr + 1;
            if (r_kr == KERNEL_SIZE - 1) begin
                w_kr_adv = '0;
                w_ic_adv = r_ic + 1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_b_nxt     = r_b;
        w_oc_nxt    = r_oc;
        w_oh_nxt    = r_oh;
        w_ow_nxt    = r_ow;
        w_ic_nxt    = r_ic;
        w_kr_nxt    = r_kr;
        w_kc_nxt    = r_kc;
        w_acc_nxt   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_b_nxt     = '0;
                    w_oc_nxt    = '0;
                    w_oh_nxt    = '0;
                    w_ow_nxt    = '0;
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                w_ic_nxt    = '0;
                w_kr_nxt    = '0;
                w_kc_nxt    = '0;
                w_state_nxt = S_BWAIT;
            end
            S_BWAIT: w_state_nxt = S_BIAS;
            S_BIAS: begin
                w_acc_nxt   = w_bias_ext;
                w_state_nxt = S_TAP;
            end
            S_TAP: begin
                if (w_cur_ok) begin
                    w_state_nxt = S_TWAIT;
                end else begin
                    w_ic_nxt    = w_ic_adv;
                    w_kr_nxt    = w_kr_adv;
                    w_kc_nxt    = w_kc_adv;
                    w_state_nxt = w_tap_last ? S_STORE : S_TAP;
                end
            end
            S_TWAIT: w_state_nxt = S_MAC;
            S_MAC: begin
                w_acc_nxt   = r_acc + w_prod;
                w_ic_nxt    = w_ic_adv;
                w_kr_nxt    = w_kr_adv;
                w_kc_nxt    = w_kc_adv;
                w_state_nxt = w_tap_last ? S_STORE : S_TAP;
            end
            S_STORE: w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (r_ow == OUT_W - 1) begin
                    w_ow_nxt = '0;
                    if (r_oh == OUT_H - 1) begin
                        w_oh_nxt = '0;
                        if (r_oc == OUT_CHANNELS - 1) begin
                            w_oc_nxt = '0;
                            w_b_nxt  = r_b + 1;
                        end else begin
                            w_oc_nxt = r_oc + 1;
                        end
                    end else begin
                        w_oh_nxt = r_oh + 1;
                    end
                end else begin
                    w_ow_nxt = r_ow + 1;
                end
                w_state_nxt = w_pix_last ? S_DONE : S_INIT;
            end
            S_DONE: begin
                if (!start) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    assign w_rd = (w_state_nxt == S_TAP) && w_nxt_ok;

    // Strobes are decoded from the next state so every port is a flop yet high in its own state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b <= '0; r_oc <= '0; r_oh <= '0; r_ow <= '0;
            r_ic <= '0; r_kr <= '0; r_kc <= '0;
            r_acc         <= '0;
            r_input_addr  <= '0;
            r_weight_addr <= '0;
            r_bias_addr   <= '0;
            r_output_addr <= '0;
            r_output_data <= '0;
            r_input_en    <= 1'b0;
            r_weight_en   <= 1'b0;
            r_bias_en     <= 1'b0;
            r_output_en   <= 1'b0;
            r_output_we   <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_b <= w_b_nxt; r_oc <= w_oc_nxt; r_oh <= w_oh_nxt; r_ow <= w_ow_nxt;
            r_ic <= w_ic_nxt; r_kr <= w_kr_nxt; r_kc <= w_kc_nxt;
            r_acc       <= w_acc_nxt;
            r_bias_en   <= (w_state_nxt == S_INIT);
            r_input_en  <= w_rd;
            r_weight_en <= w_rd;
            r_output_en <= (w_state_nxt == S_STORE);
            r_output_we <= (w_state_nxt == S_STORE);
            r_done      <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_INIT) r_bias_addr <= w_oc_nxt[AW-1:0];
            if (w_rd) begin
                r_input_addr  <= w_in_addr;
                r_weight_addr <= w_wt_addr;
            end
            if (w_state_nxt == S_STORE) begin
                r_output_addr <= w_out_addr;
                r_output_data <= w_acc_nxt[DW-1:0];
            end
        end
    end

    assign done        = r_done;
    assign valid       = r_done;
    assign input_addr  = r_input_addr;
    assign input_en    = r_input_en;
    assign weight_addr = r_weight_addr;
    assign weight_en   = r_weight_en;
    assign bias_addr   = r_bias_addr;
    assign bias_en     = r_bias_en;
    assign output_addr = r_output_addr;
    assign output_data = r_output_data;
    assign output_we   = r_output_we;
    assign output_en   = r_output_en;
endmodule
